// File: rtl/alu_datapath_if.sv
// Microinstruction, operand and status bus between the CPU-side driver and alu_datapath.
// The master drives microinstruction fields and operands; the slave returns Y, CT and MSR.
interface alu_datapath_if #(
  parameter int WIDTH = 64,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic [8:0]       I;
  logic [AW-1:0]    A;
  logic [AW-1:0]    B;
  logic [WIDTH-1:0] D;
  logic             C0;
  logic             nOE;
  logic             W32;
  logic [1:0]       SH;
  logic             nCEN;
  logic             nCEM;
  logic [3:0]       CS;
  logic [WIDTH-1:0] Y;
  logic             CT;
  logic [3:0]       MSR;

  modport master (
    output I, A, B, D, C0, nOE, W32, SH, nCEN, nCEM, CS,
    input  Y, CT, MSR
  );

  modport slave (
    input  I, A, B, D, C0, nOE, W32, SH, nCEN, nCEM, CS,
    output Y, CT, MSR
  );
endinterface

// File: rtl/alu_datapath.sv
// Bit-slice style datapath: register file, Q register, ALU, shifter, uSR/MSR status and
// condition-test output, controlled by an am2901-format microinstruction.
module alu_datapath #(
  parameter int WIDTH = 64,
  parameter int NREGS = 16
) (
  input logic           clk,
  input logic           reset,
  alu_datapath_if.slave bus
);
  localparam int MW = $clog2(WIDTH);

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] q_q;
  logic [3:0]       usr_q, msr_q;

  logic [WIDTH-1:0] mask, a_val, b_val, r_op, s_op, x_op, y_op, f, qm;
  logic [WIDTH-1:0] f_sd, f_su, f_dd, f_du, q_dd, q_du;
  logic [WIDTH-1:0] rf_wd, q_wd;
  logic [WIDTH:0]   sum;
  logic [MW-1:0]    msb;
  logic [3:0]       flags, st;
  logic             arith, c_out, c_in, fill_sd, fill_su, fill_dd, rf_we, q_we, ct_bit;

  always_comb begin
    mask  = bus.W32 ? WIDTH'(32'hFFFF_FFFF) : '1;
    msb   = bus.W32 ? MW'(31) : MW'(WIDTH - 1);
    a_val = rf_q[bus.A];
    b_val = rf_q[bus.B];

    r_op = '0;
    s_op = '0;
    unique case (bus.I[2:0])
      3'd0: begin r_op = a_val;  s_op = q_q;   end
      3'd1: begin r_op = a_val;  s_op = b_val; end
      3'd2: begin r_op = '0;     s_op = q_q;   end
      3'd3: begin r_op = '0;     s_op = b_val; end
      3'd4: begin r_op = '0;     s_op = a_val; end
      3'd5: begin r_op = bus.D;  s_op = a_val; end
      3'd6: begin r_op = bus.D;  s_op = q_q;   end
      3'd7: begin r_op = bus.D;  s_op = '0;    end
    endcase

    // Adder operands are confined to the active word so the carry emerges at bit M.
    arith = (bus.I[5:3] < 3'd3);
    x_op  = r_op;
    y_op  = s_op;
    case (bus.I[5:3])
      3'd1:    begin x_op = s_op; y_op = ~r_op; end
      3'd2:    begin x_op = r_op; y_op = ~s_op; end
      default: ;
    endcase
    x_op  = x_op & mask;
    y_op  = y_op & mask;
    sum   = {1'b0, x_op} + {1'b0, y_op} + (WIDTH + 1)'(bus.C0);
    c_out = bus.W32 ? sum[32] : sum[WIDTH];
    c_in  = sum[msb] ^ x_op[msb] ^ y_op[msb];

    unique case (bus.I[5:3])
      3'd3:    f = r_op | s_op;
      3'd4:    f = r_op & s_op;
      3'd5:    f = ~r_op & s_op;
      3'd6:    f = r_op ^ s_op;
      3'd7:    f = ~(r_op ^ s_op);
      default: f = sum[WIDTH-1:0];
    endcase
    f     = f & mask;
    flags = {arith & c_out, arith & (c_in ^ c_out), f[msb], (f == '0)};

    // Double-up fill is identical to single-up fill for every linkage mode.
    qm = q_q & mask;
    unique case (bus.SH)
      2'd0: begin fill_sd = 1'b0;     fill_su = 1'b0;     fill_dd = 1'b0;     end
      2'd1: begin fill_sd = f[0];     fill_su = f[msb];   fill_dd = qm[0];    end
      2'd2: begin fill_sd = f[msb];   fill_su = 1'b0;     fill_dd = f[msb];   end
      2'd3: begin fill_sd = msr_q[3]; fill_su = msr_q[3]; fill_dd = msr_q[3]; end
    endcase
    f_sd = (f >> 1) | (WIDTH'(fill_sd) << msb);
    f_dd = (f >> 1) | (WIDTH'(fill_dd) << msb);
    q_dd = (qm >> 1) | (WIDTH'(f[0]) << msb);
    f_su = ((f << 1) | WIDTH'(fill_su)) & mask;
    f_du = ((f << 1) | WIDTH'(qm[msb])) & mask;
    q_du = ((qm << 1) | WIDTH'(fill_su)) & mask;

    rf_we = 1'b0;
    q_we  = 1'b0;
    rf_wd = f;
    q_wd  = f;
    unique case (bus.I[8:6])
      3'd0: q_we = 1'b1;
      3'd1: ;
      3'd2: rf_we = 1'b1;
      3'd3: rf_we = 1'b1;
      3'd4: begin rf_we = 1'b1; q_we = 1'b1; rf_wd = f_dd; q_wd = q_dd; end
      3'd5: begin rf_we = 1'b1; rf_wd = f_sd; end
      3'd6: begin rf_we = 1'b1; q_we = 1'b1; rf_wd = f_du; q_wd = q_du; end
      3'd7: begin rf_we = 1'b1; rf_wd = f_su; end
    endcase

    if (bus.nOE) bus.Y = '0;
    else         bus.Y = (bus.I[8:6] == 3'd2) ? a_val : f;

    st = bus.CS[3] ? msr_q : usr_q;
    unique case (bus.CS[2:1])
      2'd0: ct_bit = st[0];
      2'd1: ct_bit = st[3];
      2'd2: ct_bit = st[1];
      2'd3: ct_bit = st[2];
    endcase
    bus.CT  = ct_bit ^ bus.CS[0];
    bus.MSR = msr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) rf_q[k] <= '0;
      q_q   <= '0;
      usr_q <= '0;
      msr_q <= '0;
    end else begin
      if (rf_we)     rf_q[bus.B] <= rf_wd;
      if (q_we)      q_q         <= q_wd;
      if (!bus.nCEN) usr_q       <= flags;
      if (!bus.nCEM) msr_q       <= flags;
    end
  end
endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: driver pushes model predictions, monitor pops and compares.
module tb_alu_datapath;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_datapath_if #(.WIDTH(64), .NREGS(16)) bus ();
  alu_datapath #(.WIDTH(64), .NREGS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic rst; logic [8:0] i; logic [3:0] a; logic [3:0] b; logic [63:0] d;
    logic c0; logic noe; logic w32; logic [1:0] sh; logic ncen; logic ncem; logic [3:0] cs;
  } stim_t;

  typedef struct {
    logic [63:0] y; logic ct; logic [3:0] msr; int kind; logic [63:0] rv; string tag;
  } exp_t;

  exp_t sbq[$];
  logic [63:0] mrf [16];
  logic [63:0] mq;
  logic [3:0]  musr, mmsr;  // {C,V,N,Z}
  int total = 0;
  int bad = 0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.i = {3'd1, 3'd3, 3'd0}; s.a = 4'd0; s.b = 4'd0; s.d = 64'd0;
    s.c0 = 1'b0; s.noe = 1'b0; s.w32 = 1'b0; s.sh = 2'd0; s.ncen = 1'b1; s.ncem = 1'b1;
    s.cs = 4'd0;
    return s;
  endfunction

  // Drives one microcycle, predicts its outputs from the reference model and advances the model.
  task automatic step(input stim_t s, input int kind, input logic [63:0] rv, input string tag);
    exp_t e;
    logic [63:0] av, bv, r, sv, x, y, f, mask, top, qm, nf, nq;
    logic [64:0] full;
    logic c, v, n, z, fl, wr_r, wr_q, stb;
    int m;
    @(posedge clk);
    #1;
    reset = s.rst; bus.I = s.i; bus.A = s.a; bus.B = s.b; bus.D = s.d; bus.C0 = s.c0;
    bus.nOE = s.noe; bus.W32 = s.w32; bus.SH = s.sh; bus.nCEN = s.ncen; bus.nCEM = s.ncem;
    bus.CS = s.cs;

    m = s.w32 ? 32 : 64;
    mask = s.w32 ? 64'h0000_0000_FFFF_FFFF : '1;
    top = 64'd1 << (m - 1);
    av = mrf[s.a]; bv = mrf[s.b];
    case (s.i[2:0])
      3'd0: begin r = av; sv = mq; end
      3'd1: begin r = av; sv = bv; end
      3'd2: begin r = 0;  sv = mq; end
      3'd3: begin r = 0;  sv = bv; end
      3'd4: begin r = 0;  sv = av; end
      3'd5: begin r = s.d; sv = av; end
      3'd6: begin r = s.d; sv = mq; end
      default: begin r = s.d; sv = 0; end
    endcase
    c = 0; v = 0;
    if (s.i[5:3] <= 3'd2) begin
      x = (s.i[5:3] == 3'd1) ? sv : r;
      y = (s.i[5:3] == 3'd0) ? sv : (s.i[5:3] == 3'd1) ? ~r : ~sv;
      x = x & mask; y = y & mask;
      full = 65'(x) + 65'(y) + 65'(s.c0);
      f = full[63:0] & mask;
      c = (full > 65'(mask));
      v = (x[m-1] == y[m-1]) && (f[m-1] != x[m-1]);
    end else begin
      case (s.i[5:3])
        3'd3: f = r | sv;
        3'd4: f = r & sv;
        3'd5: f = ~r & sv;
        3'd6: f = r ^ sv;
        default: f = ~(r ^ sv);
      endcase
      f = f & mask;
    end
    n = f[m-1]; z = (f == 0);

    e.y = s.noe ? 64'd0 : ((s.i[8:6] == 3'd2) ? av : f);
    stb = s.cs[3] ? 1'b1 : 1'b0;
    case (s.cs[2:1])
      2'd0: fl = stb ? mmsr[0] : musr[0];
      2'd1: fl = stb ? mmsr[3] : musr[3];
      2'd2: fl = stb ? mmsr[1] : musr[1];
      default: fl = stb ? mmsr[2] : musr[2];
    endcase
    e.ct = fl ^ s.cs[0];
    e.msr = mmsr;
    e.kind = kind; e.rv = rv; e.tag = tag;
    sbq.push_back(e);

    qm = mq & mask;
    nf = f; nq = f; wr_r = 1; wr_q = 0;
    case (s.i[8:6])
      3'd0: begin wr_r = 0; wr_q = 1; end
      3'd1: wr_r = 0;
      3'd4: begin
        fl = (s.sh == 0) ? 1'b0 : (s.sh == 1) ? qm[0] : (s.sh == 2) ? f[m-1] : mmsr[3];
        nf = f / 2 + (fl ? top : 64'd0);
        nq = qm / 2 + (f[0] ? top : 64'd0);
        wr_q = 1;
      end
      3'd5: begin
        fl = (s.sh == 0) ? 1'b0 : (s.sh == 1) ? f[0] : (s.sh == 2) ? f[m-1] : mmsr[3];
        nf = f / 2 + (fl ? top : 64'd0);
      end
      3'd6: begin
        fl = (s.sh == 1) ? f[m-1] : (s.sh == 3) ? mmsr[3] : 1'b0;
        nf = (f * 2 + 64'(qm[m-1])) & mask;
        nq = (qm * 2 + 64'(fl)) & mask;
        wr_q = 1;
      end
      3'd7: begin
        fl = (s.sh == 1) ? f[m-1] : (s.sh == 3) ? mmsr[3] : 1'b0;
        nf = (f * 2 + 64'(fl)) & mask;
      end
      default: ;
    endcase
    if (s.rst) begin
      for (int k = 0; k < 16; k++) mrf[k] = 0;
      mq = 0; musr = 0; mmsr = 0;
    end else begin
      if (wr_r) mrf[s.b] = nf;
      if (wr_q) mq = nq;
      if (!s.ncen) musr = {c, v, n, z};
      if (!s.ncem) mmsr = {c, v, n, z};
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp($sformatf("y[%s]", e.tag), bus.Y, e.y);
        cmp($sformatf("ct[%s]", e.tag), 64'(bus.CT), 64'(e.ct));
        cmp($sformatf("msr[%s]", e.tag), 64'(bus.MSR), 64'(e.msr));
        if (e.kind == 1) cmp($sformatf("dir_y[%s]", e.tag), bus.Y, e.rv);
        if (e.kind == 2) cmp($sformatf("dir_ct[%s]", e.tag), 64'(bus.CT), 64'(e.rv[0]));
        if (e.kind == 3) cmp($sformatf("dir_msr[%s]", e.tag), 64'(bus.MSR), 64'(e.rv[3:0]));
      end
    end
  end

  initial begin : driver
    stim_t s;
    logic [63:0] picks [5];
    picks[0] = 64'd0; picks[1] = '1; picks[2] = 64'h8000_0000_0000_0000;
    picks[3] = 64'h7FFF_FFFF_FFFF_FFFF; picks[4] = 64'h0000_0000_FFFF_FFFF;
    s = idle();
    reset = 1'b1;
    bus.I = s.i; bus.A = 0; bus.B = 0; bus.D = 0; bus.C0 = 0; bus.nOE = 0; bus.W32 = 0;
    bus.SH = 0; bus.nCEN = 1; bus.nCEM = 1; bus.CS = 0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 16; k++) mrf[k] = 0;
    mq = 0; musr = 0; mmsr = 0;

    s = idle(); s.rst = 1; s.cs = 4'h1; step(s, 2, 64'd1, "rst_ct");
    s = idle(); s.rst = 1; step(s, 3, 64'd0, "rst_msr");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 3; s.d = 5; step(s, 1, 64'd5, "dz_add");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 3; step(s, 1, 64'd5, "read_r3");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 1; s.d = 64'h7FFF_FFFF_FFFF_FFFF;
    step(s, 1, 64'h7FFF_FFFF_FFFF_FFFF, "load_r1");
    s = idle(); s.i = {3'd1, 3'd0, 3'd5}; s.a = 1; s.d = 1; s.ncen = 0;
    step(s, 1, 64'h8000_0000_0000_0000, "ovf_add");
    s = idle(); s.cs = 4'd6; step(s, 2, 64'd1, "usr_v");
    s = idle(); s.cs = 4'd4; step(s, 2, 64'd1, "usr_n");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 5; s.d = 1; step(s, 1, 64'd1, "load_r5");
    s = idle(); s.i = {3'd3, 3'd0, 3'd5}; s.a = 5; s.b = 6; s.d = 64'hFFFF_FFFF; s.w32 = 1;
    s.ncem = 0; step(s, 1, 64'd0, "w32_add");
    s = idle(); step(s, 3, 64'h9, "w32_msr");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 6; step(s, 1, 64'd0, "w32_upper");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 2; s.d = 64'h8000_0000_0000_0001;
    step(s, 0, 64'd0, "load_r2");
    s = idle(); s.i = {3'd0, 3'd0, 3'd7}; step(s, 0, 64'd0, "clear_q");
    s = idle(); s.i = {3'd4, 3'd3, 3'd3}; s.b = 2; s.sh = 2;
    step(s, 1, 64'h8000_0000_0000_0001, "dbl_down");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 2; step(s, 1, 64'hC000_0000_0000_0000, "dd_reg");
    s = idle(); s.i = {3'd1, 3'd3, 3'd2}; step(s, 1, 64'h8000_0000_0000_0000, "dd_q");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 7; s.d = 64'h8000_0000_0000_0000;
    step(s, 0, 64'd0, "load_r7");
    s = idle(); s.i = {3'd7, 3'd3, 3'd3}; s.b = 7; s.sh = 1; step(s, 0, 64'd0, "rot_up");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 7; step(s, 1, 64'd1, "rot_up_rd");
    s = idle(); s.i = {3'd1, 3'd0, 3'd5}; s.a = 5; s.d = '1; s.ncem = 0;
    step(s, 1, 64'd0, "set_c");
    s = idle(); s.i = {3'd3, 3'd0, 3'd7}; s.b = 8; s.d = 0; step(s, 0, 64'd0, "load_r8");
    s = idle(); s.i = {3'd5, 3'd3, 3'd3}; s.b = 8; s.sh = 3; step(s, 0, 64'd0, "c_down");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 8;
    step(s, 1, 64'h8000_0000_0000_0000, "c_down_rd");
    s = idle(); s.rst = 1; s.ncem = 0; s.i = {3'd3, 3'd0, 3'd7}; s.b = 4; s.d = 64'h1234;
    step(s, 0, 64'd0, "rst_wr");
    s = idle(); s.cs = 4'd7; step(s, 3, 64'd0, "rst_wr_msr");
    s = idle(); s.i = {3'd1, 3'd3, 3'd3}; s.b = 4; step(s, 1, 64'd0, "rst_wr_r4");
    s = idle(); s.cs = 4'd7; step(s, 2, 64'd1, "rst_wr_ct");

    for (int t = 0; t < 400; t++) begin
      s.rst = ($urandom_range(0, 39) == 0);
      s.i = 9'($urandom); s.a = 4'($urandom); s.b = 4'($urandom);
      s.d = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 4)] : {$urandom, $urandom};
      s.c0 = 1'($urandom); s.noe = ($urandom_range(0, 7) == 0); s.w32 = 1'($urandom);
      s.sh = 2'($urandom); s.ncen = 1'($urandom); s.ncem = 1'($urandom); s.cs = 4'($urandom);
      step(s, 0, 64'd0, "rand");
    end

    repeat (3) @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_datapath.md
# alu_datapath

Parametrised bit-slice integer datapath: a 16-entry two-port register file, Q register, ALU, shifter and dual status registers with condition-test output, driven by an am2901-format 9-bit microinstruction. Replaces a fixed 64-bit chain of 4-bit slices plus status chip with one block that scales in width, selects 32/64-bit result mode, and decides shift linkage internally. It sits between the CPU D/Y buses and the microsequencer condition multiplexer.

## Interface
- WIDTH, 64: datapath width; multiple of 4, at least 32.
- NREGS, 16: register-file depth; power of two.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- I  in  9  microinstruction: I[2:0] source, I[5:3] function, I[8:6] destination.
- A  in  log2(NREGS)  read address, port A.
- B  in  log2(NREGS)  read/write address, port B.
- D  in  WIDTH  external data operand.
- C0  in  1  ALU carry-in.
- nOE  in  1  Y output enable, active-low; Y=0 when high.
- W32  in  1  1 = 32-bit result mode.
- SH  in  2  shift linkage: 0 zero fill, 1 rotate, 2 arithmetic, 3 fill from machine carry.
- nCEN  in  1  micro status register load enable, active-low.
- nCEM  in  1  machine status register load enable, active-low.
- CS  in  4  condition select for CT.
- Y  out  WIDTH  data output.
- CT  out  1  condition test result.
- MSR  out  4  machine status {C,V,N,Z}.

## Operation
- Sources (R,S): 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
- Functions: 0 R+S+C0; 1 S+~R+C0; 2 R+~S+C0; 3 R|S; 4 R&S; 5 ~R&S; 6 R^S; 7 ~(R^S).
- Destinations: 0 F->Q, Y=F; 1 none, Y=F; 2 F->reg[B], Y=A-port; 3 F->reg[B], Y=F; 4 double down (F/2->reg[B], Q/2->Q), Y=F; 5 F/2->reg[B], Y=F; 6 double up (2F->reg[B], 2Q->Q), Y=F; 7 2F->reg[B], Y=F.
- Word width M = 32 if W32 else WIDTH. F bits [WIDTH-1:M] forced 0 before Y, writeback and shifting; shifts act on bits [M-1:0].
- Flags from F: C = carry out of bit M-1 (0 for logic functions); V = carry into bit M-1 xor carry out (0 for logic); N = F[M-1]; Z = F[M-1:0]==0.
- Single down: F' = {fill, F[M-1:1]}; single up: F' = {F[M-2:0], fill}. Fill: SH0 0; SH1 F[0] (down) / F[M-1] (up); SH2 F[M-1] (down) / 0 (up); SH3 MSR.C.
- Double down: F' = {fill, F[M-1:1]}, Q' = {F[0], Q[M-1:1]}; rotate fill = Q[0]. Double up: F' = {F[M-2:0], Q[M-1]}, Q' = {Q[M-2:0], fill}; rotate fill = F[M-1]. SH2/SH3 as single.
- Micro status uSR loads flags when nCEN=0; MSR loads flags when nCEM=0; both may load in the same cycle.
- CT: CS[3] selects MSR (1) or uSR (0); CS[2:1] selects Z,C,N,V (0..3); CS[0]=1 inverts.

## Timing
- Reset: all registers, Q, uSR, MSR cleared to 0; writes and status loads suppressed in the reset cycle. Outputs after reset: MSR=0, CT = CS[0], Y = F computed from zeroed state (0 when nOE=1).
- Y, flags: combinational from current inputs/state, zero latency.
- Register, Q, uSR, MSR updates at rising clk; visible in the next cycle.
- Same-cycle read of reg[B] while writing it returns the old value; A==B legal.
- CT depends only on registered status and CS: flag changes appear in CT one cycle after the load.
- Reset asserted mid-sequence overrides any pending write or load in that cycle.

## Test plan
- Reset; I=DZ,ADD,F->reg[B], D=5, B=3; next cycle source 0,B, B=3, OR -> Y=5.
- reg[1]=0x7FFF_FFFF_FFFF_FFFF; D=1, source D,A, A=1, ADD, nCEN=0 -> Y=0x8000_0000_0000_0000; next cycle CS=6 -> CT=1, CS=4 -> CT=1.
- W32=1, D=0xFFFF_FFFF, A-reg=1, ADD, nCEM=0 -> Y=0, MSR={1,0,0,1}; upper 32 bits of written reg are 0.
- reg[2]=0x8000_0000_0000_0001, Q=0, SH=2, double down -> reg[2]=0xC000_0000_0000_0000, Q=0x8000_0000_0000_0000.
- SH=1, single up on 0x8000_0000_0000_0000 -> 0x0000_0000_0000_0001; SH=3 with MSR.C=1, single down on 0 -> 0x8000_0000_0000_0000.
- reset=1 coincident with nCEM=0, write to reg[4] -> MSR=0, reg[4] unchanged at 0, CT=CS[0].
